ysyx_23060203_wbu: RTL and testbench
====================================

YSYX_23060203_WBU -- requirements
Module: ysyx_23060203_wbu

Interface
REQ-001 SHALL have parameter NR_REG, default 16, meaning the number of architectural registers tracked (x0..x15).
REQ-002 SHALL have parameter XLEN, default 32, meaning the data width.
REQ-003 clk  in  1  clock; all state updates on posedge.
REQ-004 rstn  in  1  reset, synchronous, active-low.
REQ-005 iss_valid  in  1  issue stage dispatching an instruction with destination iss_rd.
REQ-006 iss_rd  in  5  destination register of the dispatched instruction.
REQ-007 iss_ready  out  1  dispatch accepted; low when iss_rd is already busy (WAW stall).
REQ-008 raddr1, raddr2  in  5 each  source registers of the instruction in issue.
REQ-009 raw_hazard  out  1  a source register has a pending, unwritten result.
REQ-010 exu_valid, exu_rd, exu_data  in  1/5/XLEN  ALU result offer.
REQ-011 exu_ready  out  1  ALU result accepted this cycle.
REQ-012 lsu_valid, lsu_rd, lsu_data  in  1/5/XLEN  load result offer.
REQ-013 lsu_ready  out  1  load result accepted this cycle.
REQ-014 rf_wen, rf_waddr, rf_wdata  out  1/5/XLEN  register-file write port, all registered.
REQ-015 retire_cnt  out  32  count of accepted results.
REQ-016 rd_err  out  1  sticky flag: an rd >= NR_REG was seen.

Function
REQ-017 Scoreboard: busy[1..NR_REG-1]; busy[0] is constant 0.
REQ-018 An issue handshake (iss_valid && iss_ready) with iss_rd != 0 and iss_rd < NR_REG SHALL set busy[iss_rd] at the next edge.
REQ-019 iss_ready SHALL equal !busy[iss_rd], combinationally.
REQ-020 raw_hazard SHALL equal busy[raddr1] | busy[raddr2], combinationally; an index of 0 or >= NR_REG contributes 0.
REQ-021 Arbitration: at most one of exu_ready and lsu_ready SHALL be high per cycle; the output stage always accepts, so no backpressure beyond arbitration.
REQ-022 If only one source is valid, that source SHALL be accepted.
REQ-023 If both sources are valid, round-robin SHALL apply: LSU wins unless LSU won the previous contended cycle.
REQ-024 Pointer: the round-robin pointer SHALL update only on contended cycles.
REQ-025 Accepted result with rd != 0 and rd < NR_REG: the next edge SHALL set rf_wen=1, rf_waddr=rd, rf_wdata=data (latency 1 cycle).
REQ-026 Accepted result with rd == 0: it SHALL be dropped; rf_wen=0 at the next edge; retire_cnt SHALL still increment.
REQ-027 No accept: rf_wen SHALL be 0 at the next edge; rf_waddr and rf_wdata SHALL hold.
REQ-028 busy[rf_waddr] SHALL clear on the edge that ends the rf_wen=1 cycle, coincident with the register-file write.
REQ-029 raw_hazard for that register SHALL drop the following cycle.
REQ-030 Set and clear of the same register on one edge: set SHALL win. This is unreachable through the handshake; defensive only.
REQ-031 rd >= NR_REG on any port: the result SHALL be accepted and dropped, and rd_err set (sticky until reset); the scoreboard SHALL be unaffected.
REQ-032 retire_cnt SHALL increment by 1 per accepted result, wrapping modulo 2^32.

Reset
REQ-033 While rstn=0 at posedge, the following SHALL clear:
  - busy to all 0;
  - rf_wen=0, rf_waddr=0, rf_wdata=0;
  - retire_cnt=0, rd_err=0;
  - round-robin pointer to favour LSU.
REQ-034 Reset mid-operation SHALL discard in-flight results with no rf write; exu_ready and lsu_ready SHALL be 0 during reset.
REQ-035 iss_ready SHALL be 0 during reset.

Structure
REQ-036 Shared package ysyx_23060203_pkg SHALL hold REG_AW=5, XLEN=32 and the arbiter source encoding (SRC_EXU, SRC_LSU).
REQ-037 The scoreboard (busy bits, set/clear, two hazard reads, one WAW read) SHALL be the sub-module ysyx_23060203_scoreboard; arbitration and the output register SHALL stay in the top module.

Verification
REQ-038 Issue rd=5, then an EXU result rd=5, data 0x1234 -> raw_hazard high while raddr1=5; rf_wen=1, waddr=5, wdata=0x1234 one cycle after accept; raw_hazard low the cycle after that.
REQ-039 EXU and LSU both valid for 4 cycles (rd 3/4) -> accepts LSU, EXU, LSU, EXU; retire_cnt=4.
REQ-040 Issue rd=7 twice back-to-back -> second cycle iss_ready=0 until the rd=7 result is written.
REQ-041 LSU result rd=0, data 0xFFFFFFFF -> rf_wen stays 0; retire_cnt increments; no busy change.
REQ-042 EXU result rd=20 -> accepted, rf_wen=0, rd_err=1 and held; busy unchanged.
REQ-043 Issue rd=9, then rstn low for 1 cycle with a result in flight -> busy cleared, rf_wen=0, retire_cnt=0, raw_hazard=0 after reset.

Source files
------------

// File: rtl/ysyx_23060203_pkg.sv
// Shared widths, arbiter source encoding and the register-tracking predicate
// used by the write-back unit and its scoreboard.
package ysyx_23060203_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  typedef enum logic {
    SRC_EXU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  // True for registers the scoreboard tracks: x1..x(nr_reg-1).
  function automatic logic rd_tracked(input logic [REG_AW-1:0] rd, input int nr_reg);
    return (rd != '0) && (int'(rd) < nr_reg);
  endfunction

  function automatic logic rd_out_of_range(input logic [REG_AW-1:0] rd, input int nr_reg);
    return !(int'(rd) < nr_reg);
  endfunction

endpackage

// File: rtl/ysyx_23060203_scoreboard.sv
// Busy-bit scoreboard: one set port (issue), one clear port (write-back),
// two RAW read ports and one WAW read port.
module ysyx_23060203_scoreboard
  import ysyx_23060203_pkg::*;
#(
  parameter int NR_REG = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_rd,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] waw_rd,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              waw_busy
);

  localparam int NSLOT = 1 << REG_AW;

  // Sized to the full index space so any 5-bit rd reads safely; bit 0 and
  // bits >= NR_REG are never written and stay 0.
  logic [NSLOT-1:0] busy;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy <= '0;
    end else begin
      if (clr_en && rd_tracked(clr_rd, NR_REG)) busy[clr_rd] <= 1'b0;
      // Set is applied last so it wins over a same-edge clear.
      if (set_en && rd_tracked(set_rd, NR_REG)) busy[set_rd] <= 1'b1;
    end
  end

  always_comb begin
    rs1_busy = busy[rs1];
    rs2_busy = busy[rs2];
    waw_busy = busy[waw_rd];
  end

endmodule

// File: rtl/ysyx_23060203_wbu.sv
// Write-back unit: tracks pending destinations, arbitrates EXU/LSU results
// round-robin and drives a registered register-file write port.
module ysyx_23060203_wbu
  import ysyx_23060203_pkg::*;
#(
  parameter int NR_REG = 16,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  output logic              iss_ready,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic              raw_hazard,
  input  logic              exu_valid,
  input  logic [REG_AW-1:0] exu_rd,
  input  logic [XLEN-1:0]   exu_data,
  output logic              exu_ready,
  input  logic              lsu_valid,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              lsu_ready,
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic [31:0]       retire_cnt,
  output logic              rd_err
);

  logic rs1_busy, rs2_busy, waw_busy;

  // Source that won the most recent contended cycle.
  src_e last_win;

  logic              accept;
  src_e              win;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;

  ysyx_23060203_scoreboard #(
    .NR_REG (NR_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rstn     (rstn),
    .set_en   (iss_valid && iss_ready),
    .set_rd   (iss_rd),
    .clr_en   (rf_wen),
    .clr_rd   (rf_waddr),
    .rs1      (raddr1),
    .rs2      (raddr2),
    .waw_rd   (iss_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .waw_busy (waw_busy)
  );

  always_comb begin
    iss_ready  = rstn && !waw_busy;
    raw_hazard = rs1_busy | rs2_busy;

    accept = rstn && (exu_valid || lsu_valid);
    if (exu_valid && lsu_valid) win = (last_win == SRC_LSU) ? SRC_EXU : SRC_LSU;
    else if (lsu_valid)         win = SRC_LSU;
    else                        win = SRC_EXU;

    exu_ready = accept && (win == SRC_EXU);
    lsu_ready = accept && (win == SRC_LSU);
    sel_rd    = (win == SRC_LSU) ? lsu_rd   : exu_rd;
    sel_data  = (win == SRC_LSU) ? lsu_data : exu_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_win   <= SRC_EXU;
      rf_wen     <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      retire_cnt <= '0;
      rd_err     <= 1'b0;
    end else begin
      rf_wen <= 1'b0;
      if (exu_valid && lsu_valid) last_win <= win;
      if (accept) begin
        retire_cnt <= retire_cnt + 32'd1;
        if (rd_out_of_range(sel_rd, NR_REG)) begin
          rd_err <= 1'b1;
        end else if (sel_rd != '0) begin
          rf_wen   <= 1'b1;
          rf_waddr <= sel_rd;
          rf_wdata <= sel_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060203_wbu.sv
// Scoreboard bench for the write-back unit: a cycle-level reference model
// predicts handshakes and register-file writes; a monitor checks the writes.
module tb_ysyx_23060203_wbu;

  localparam int NR = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic        iss_ready;
  logic [4:0]  raddr1 = '0, raddr2 = '0;
  logic        raw_hazard;
  logic        exu_valid = 1'b0;
  logic [4:0]  exu_rd = '0;
  logic [31:0] exu_data = '0;
  logic        exu_ready;
  logic        lsu_valid = 1'b0;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic        lsu_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] retire_cnt;
  logic        rd_err;

  ysyx_23060203_wbu #(.NR_REG(NR), .XLEN(32)) dut (
    .clk(clk), .rstn(rstn),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .raddr1(raddr1), .raddr2(raddr2), .raw_hazard(raw_hazard),
    .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data), .exu_ready(exu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .retire_cnt(retire_cnt), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q[$];

  // Reference model state
  bit          busy_m[32];
  int unsigned retire_m = 0;
  bit          err_m = 0;
  bit          lsu_won_last = 0;
  int          pend_clr = -1;
  logic        m_wen = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented write must match the oldest predicted write.
  always @(posedge clk) begin
    wr_t e;
    #1;
    if (rf_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write", rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(rf_waddr), 64'(e.a));
        chk("wr_data", 64'(rf_wdata), 64'(e.d));
      end
    end
  end

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    bit iss_ok, acc, both, win_lsu;
    int rd;
    logic [31:0] d;
    int nclr;
    #2;
    iss_ok  = rstn && !busy_m[iss_rd];
    acc     = rstn && (exu_valid || lsu_valid);
    both    = exu_valid && lsu_valid;
    win_lsu = lsu_valid && !(both && lsu_won_last);
    chk("iss_ready",  64'(iss_ready),  64'(iss_ok));
    chk("raw_hazard", 64'(raw_hazard), 64'(busy_m[raddr1] | busy_m[raddr2]));
    chk("exu_ready",  64'(exu_ready),  64'(acc && !win_lsu));
    chk("lsu_ready",  64'(lsu_ready),  64'(acc && win_lsu));
    chk("rf_wen",     64'(rf_wen),     64'(m_wen));
    chk("rf_waddr",   64'(rf_waddr),   64'(m_addr));
    chk("rf_wdata",   64'(rf_wdata),   64'(m_data));
    chk("retire_cnt", 64'(retire_cnt), 64'(retire_m));
    chk("rd_err",     64'(rd_err),     64'(err_m));
    @(posedge clk);
    if (!rstn) begin
      foreach (busy_m[i]) busy_m[i] = 0;
      retire_m = 0; err_m = 0; lsu_won_last = 0; pend_clr = -1;
      m_wen = 0; m_addr = '0; m_data = '0;
    end else begin
      if (pend_clr > 0) busy_m[pend_clr] = 0;
      nclr  = -1;
      m_wen = 0;
      if (acc) begin
        rd = win_lsu ? int'(lsu_rd) : int'(exu_rd);
        d  = win_lsu ? lsu_data : exu_data;
        retire_m++;
        if (both) lsu_won_last = win_lsu;
        if (rd >= NR) err_m = 1;
        else if (rd != 0) begin
          exp_q.push_back('{a: 5'(rd), d: d});
          m_wen = 1; m_addr = 5'(rd); m_data = d; nclr = rd;
        end
      end
      if (iss_valid && iss_ok && iss_rd != 0 && int'(iss_rd) < NR) busy_m[iss_rd] = 1;
      pend_clr = nclr;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    iss_valid = 0; exu_valid = 0; lsu_valid = 0;
    repeat (n) step();
  endtask

  initial begin
    foreach (busy_m[i]) busy_m[i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step();                       // reset state
    rstn = 1;
    idle(1);

    // issue x5, result for x5, hazard rises then falls
    iss_valid = 1; iss_rd = 5; step();
    iss_valid = 0; raddr1 = 5; exu_valid = 1; exu_rd = 5; exu_data = 32'h1234; step();
    exu_valid = 0; step(); step(); step();
    raddr1 = 0;

    // contention: LSU, EXU, LSU, EXU
    exu_valid = 1; exu_rd = 3; exu_data = 32'hAAAA0003;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 32'hBBBB0004;
    repeat (4) step();
    idle(2);

    // WAW stall on x7
    iss_valid = 1; iss_rd = 7; step(); step();
    exu_valid = 1; exu_rd = 7; exu_data = 32'h77; step();
    exu_valid = 0; step(); step(); step();
    iss_valid = 0; exu_valid = 1; exu_rd = 7; exu_data = 32'h78; step();
    idle(2);

    // write to x0 is dropped but retired
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hFFFFFFFF; step();
    idle(2);

    // out-of-range rd sets sticky error
    exu_valid = 1; exu_rd = 20; exu_data = 32'hDEAD; step();
    idle(3);

    // reset with a result in flight
    iss_valid = 1; iss_rd = 9; step();
    iss_valid = 0; exu_valid = 1; exu_rd = 9; exu_data = 32'h99; rstn = 0; step();
    exu_valid = 0; rstn = 1; raddr1 = 9; step(); step();

    // randomized traffic
    for (int c = 0; c < 500; c++) begin
      rstn      = ($urandom_range(0, 99) != 0);
      iss_valid = $urandom_range(0, 1);
      iss_rd    = 5'($urandom_range(0, 17));
      raddr1    = 5'($urandom_range(0, 31));
      raddr2    = 5'($urandom_range(0, 15));
      exu_valid = ($urandom_range(0, 2) != 0);
      exu_rd    = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
      exu_data  = $urandom;
      lsu_valid = $urandom_range(0, 1);
      lsu_rd    = 5'($urandom_range(0, 15));
      lsu_data  = $urandom;
      step();
    end
    rstn = 1;
    idle(3);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
